conv_window_seq: RTL and testbench

- Operand sequencer that sits directly upstream of the saturating Q8.8 MAC unit.
- On a start pulse it walks one K x K x C convolution window. It reads activations and weights from two 1-cycle-latency SRAMs and streams operand pairs into the MAC.
- The running sum is chained through the MAC's registered output, seeded with the bias.
- When the window completes, it returns the final Q8.8 result over a valid/ready handshake to the feature-map writer.

---
 rtl/conv_window_seq_pkg.sv | 18 +
 rtl/conv_window_seq_win_addr_gen.sv | 78 +++++++
 rtl/conv_window_seq.sv | 200 ++++++++++++++++++++
 tb/tb_conv_window_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_seq_pkg.sv
// Shared types and constants for the convolution window operand sequencer.
package conv_window_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    WAIT,
    OUT
  } state_t;

  localparam logic [15:0] Q_ONE = 16'h0100;
  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN = 16'h8000;

  localparam int KMAX_DEF = 5;

endpackage

// File: rtl/conv_window_seq_win_addr_gen.sv
// Window address generator: kx/ky/ch counters with incremental row/channel
// base adders; reports first and last term of the window.
module win_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int CH_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [2:0]        ksize,
  input  logic [CH_W-1:0]   ch_cnt,
  input  logic [ADDR_W-1:0] ifm_base,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic [ADDR_W-1:0] ch_stride,
  output logic [ADDR_W-1:0] ifm_addr,
  output logic [ADDR_W-1:0] w_addr,
  output logic              first,
  output logic              last
);

  logic [2:0]        kx_reg;
  logic [2:0]        ky_reg;
  logic [CH_W-1:0]   ch_reg;
  logic [ADDR_W-1:0] row_base_reg;
  logic [ADDR_W-1:0] ch_base_reg;
  logic [ADDR_W-1:0] w_addr_reg;

  logic kx_end;
  logic ky_end;
  logic ch_end;

  assign kx_end = (kx_reg == ksize - 3'd1);
  assign ky_end = (ky_reg == ksize - 3'd1);
  assign ch_end = (ch_reg == ch_cnt - CH_W'(1));

  assign ifm_addr = row_base_reg + ADDR_W'(kx_reg);
  assign w_addr   = w_addr_reg;
  assign first    = (kx_reg == 3'd0) && (ky_reg == 3'd0) && (ch_reg == '0);
  assign last     = kx_end && ky_end && ch_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kx_reg       <= '0;
      ky_reg       <= '0;
      ch_reg       <= '0;
      row_base_reg <= '0;
      ch_base_reg  <= '0;
      w_addr_reg   <= '0;
    end else if (load) begin
      kx_reg       <= '0;
      ky_reg       <= '0;
      ch_reg       <= '0;
      row_base_reg <= ifm_base;
      ch_base_reg  <= ifm_base;
      w_addr_reg   <= w_base;
    end else if (step) begin
      w_addr_reg <= w_addr_reg + ADDR_W'(1);
      if (kx_end) begin
        kx_reg <= '0;
        if (ky_end) begin
          // New channel: both bases restart from the next channel plane.
          ky_reg       <= '0;
          ch_reg       <= ch_reg + CH_W'(1);
          ch_base_reg  <= ch_base_reg + ch_stride;
          row_base_reg <= ch_base_reg + ch_stride;
        end else begin
          ky_reg       <= ky_reg + 3'd1;
          row_base_reg <= row_base_reg + row_stride;
        end
      end else begin
        kx_reg <= kx_reg + 3'd1;
      end
    end
  end

endmodule

// File: rtl/conv_window_seq.sv
// Convolution window operand sequencer feeding a saturating Q8.8 MAC.
// Optional ReLU on the result is enabled by defining CONV_RELU_EN.
module conv_window_seq
  import conv_window_seq_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int KMAX   = KMAX_DEF,
  parameter int CH_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  input  logic [2:0]        cfg_ksize,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [15:0]       cfg_bias,
  input  logic [ADDR_W-1:0] cfg_ifm_base,
  input  logic [ADDR_W-1:0] cfg_row_stride,
  input  logic [ADDR_W-1:0] cfg_ch_stride,
  input  logic [ADDR_W-1:0] cfg_w_base,
  output logic              ifm_rd,
  output logic [ADDR_W-1:0] ifm_addr,
  input  logic [15:0]       ifm_rdata,
  output logic              w_rd,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [15:0]       w_rdata,
  output logic              mac_valid,
  output logic [15:0]       mac_in1,
  output logic [15:0]       mac_in2,
  output logic [15:0]       mac_in3,
  input  logic [15:0]       mac_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [15:0]       res_data
);

  localparam logic [2:0] KMAX_K = 3'(KMAX);

  state_t state_reg;
  state_t state_next;

  logic [2:0]        ksize_reg;
  logic [CH_W-1:0]   ch_cnt_reg;
  logic [15:0]       bias_reg;
  logic [ADDR_W-1:0] row_stride_reg;
  logic [ADDR_W-1:0] ch_stride_reg;

  logic              rd_reg;
  logic              rd_first_reg;
  logic              rd_last_reg;
  logic [ADDR_W-1:0] ifm_addr_reg;
  logic [ADDR_W-1:0] w_addr_reg;
  logic              mac_valid_reg;
  logic              mac_first_reg;
  logic              mac_last_reg;
  logic [15:0]       res_data_reg;

  logic              gen_load;
  logic              gen_step;
  logic              gen_first;
  logic              gen_last;
  logic [ADDR_W-1:0] gen_ifm_addr;
  logic [ADDR_W-1:0] gen_w_addr;

  logic [2:0] k_eff;
  logic       n_zero;

  function automatic logic [15:0] post_proc(input logic [15:0] v);
`ifdef CONV_RELU_EN
    post_proc = ((v & Q_MIN) != 16'h0000) ? 16'h0000 : v;
`else
    post_proc = v;
`endif
  endfunction

  assign k_eff  = (cfg_ksize > KMAX_K) ? KMAX_K : cfg_ksize;
  assign n_zero = (k_eff == 3'd0) || (cfg_ch == '0);

  win_addr_gen #(
    .ADDR_W (ADDR_W),
    .CH_W   (CH_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (gen_load),
    .step       (gen_step),
    .ksize      (ksize_reg),
    .ch_cnt     (ch_cnt_reg),
    .ifm_base   (cfg_ifm_base),
    .w_base     (cfg_w_base),
    .row_stride (row_stride_reg),
    .ch_stride  (ch_stride_reg),
    .ifm_addr   (gen_ifm_addr),
    .w_addr     (gen_w_addr),
    .first      (gen_first),
    .last       (gen_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    gen_load   = 1'b0;
    gen_step   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          gen_load   = 1'b1;
          state_next = n_zero ? OUT : FETCH;
        end
      end
      FETCH: begin
        gen_step = 1'b1;
        if (gen_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (mac_valid_reg && mac_last_reg) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        state_next = OUT;
      end
      OUT: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ksize_reg      <= '0;
      ch_cnt_reg     <= '0;
      bias_reg       <= '0;
      row_stride_reg <= '0;
      ch_stride_reg  <= '0;
      rd_reg         <= 1'b0;
      rd_first_reg   <= 1'b0;
      rd_last_reg    <= 1'b0;
      ifm_addr_reg   <= '0;
      w_addr_reg     <= '0;
      mac_valid_reg  <= 1'b0;
      mac_first_reg  <= 1'b0;
      mac_last_reg   <= 1'b0;
      res_data_reg   <= '0;
    end else begin
      rd_reg       <= gen_step;
      rd_first_reg <= gen_step & gen_first;
      rd_last_reg  <= gen_step & gen_last;
      if (gen_step) begin
        ifm_addr_reg <= gen_ifm_addr;
        w_addr_reg   <= gen_w_addr;
      end
      // SRAM data lands one cycle after the strobe, so the MAC stage lags by one.
      mac_valid_reg <= rd_reg;
      mac_first_reg <= rd_first_reg;
      mac_last_reg  <= rd_last_reg;
      if (gen_load) begin
        ksize_reg      <= k_eff;
        ch_cnt_reg     <= cfg_ch;
        bias_reg       <= cfg_bias;
        row_stride_reg <= cfg_row_stride;
        ch_stride_reg  <= cfg_ch_stride;
        if (n_zero) begin
          res_data_reg <= post_proc(cfg_bias);
        end
      end
      if (state_reg == WAIT) begin
        res_data_reg <= post_proc(mac_out);
      end
    end
  end

  assign busy      = (state_reg != IDLE);
  assign res_valid = (state_reg == OUT);
  assign res_data  = res_data_reg;
  assign ifm_rd    = rd_reg;
  assign w_rd      = rd_reg;
  assign ifm_addr  = ifm_addr_reg;
  assign w_addr    = w_addr_reg;
  assign mac_valid = mac_valid_reg;
  // The first term is seeded with the bias; later terms chain the MAC's registered sum.
  assign mac_in1   = mac_valid_reg ? (mac_first_reg ? bias_reg : mac_out) : 16'h0000;
  assign mac_in2   = mac_valid_reg ? ifm_rdata : 16'h0000;
  assign mac_in3   = mac_valid_reg ? w_rdata : 16'h0000;

endmodule

// File: tb/tb_conv_window_seq.sv
// Table-driven bench for conv_window_seq with SRAM and saturating Q8.8 MAC models.
module tb_conv_window_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic [2:0]  cfg_ksize;
  logic [7:0]  cfg_ch;
  logic [15:0] cfg_bias;
  logic [15:0] cfg_ifm_base;
  logic [15:0] cfg_row_stride;
  logic [15:0] cfg_ch_stride;
  logic [15:0] cfg_w_base;
  logic        ifm_rd;
  logic [15:0] ifm_addr;
  logic [15:0] ifm_rdata;
  logic        w_rd;
  logic [15:0] w_addr;
  logic [15:0] w_rdata;
  logic        mac_valid;
  logic [15:0] mac_in1;
  logic [15:0] mac_in2;
  logic [15:0] mac_in3;
  logic [15:0] mac_out;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;

  int checks;
  int failures;

  logic [15:0] ifm_mem [0:4095];
  logic [15:0] w_mem   [0:4095];

  logic [15:0] ifm_log [$];
  logic [15:0] w_log   [$];
  int          mac_cnt;
  int          pair_err;
  logic [15:0] first_in1;

  typedef struct {
    logic [2:0]  k;
    logic [7:0]  c;
    logic [15:0] bias;
    logic [15:0] ifm_base;
    logic [15:0] rs;
    logic [15:0] cs;
    logic [15:0] wb;
    logic [15:0] ifm_val;
    logic [15:0] w_val;
    logic [15:0] exp_res;
    int          n;
  } vec_t;

  vec_t vecs [8];
  vec_t rv;

  conv_window_seq dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .cfg_ksize      (cfg_ksize),
    .cfg_ch         (cfg_ch),
    .cfg_bias       (cfg_bias),
    .cfg_ifm_base   (cfg_ifm_base),
    .cfg_row_stride (cfg_row_stride),
    .cfg_ch_stride  (cfg_ch_stride),
    .cfg_w_base     (cfg_w_base),
    .ifm_rd         (ifm_rd),
    .ifm_addr       (ifm_addr),
    .ifm_rdata      (ifm_rdata),
    .w_rd           (w_rd),
    .w_addr         (w_addr),
    .w_rdata        (w_rdata),
    .mac_valid      (mac_valid),
    .mac_in1        (mac_in1),
    .mac_in2        (mac_in2),
    .mac_in3        (mac_in3),
    .mac_out        (mac_out),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mac_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c);
    logic signed [31:0] p;
    logic signed [31:0] s;
    p = $signed(b) * $signed(c);
    s = $signed({{16{a[15]}}, a}) + (p >>> 8);
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
  endfunction

  function automatic logic [15:0] exp_post(input logic [15:0] v);
`ifdef CONV_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  initial mac_out = 16'h0000;
  always @(posedge clk) begin
    if (mac_valid) mac_out <= mac_f(mac_in1, mac_in2, mac_in3);
    if (ifm_rd) ifm_rdata <= ifm_mem[ifm_addr[11:0]];
    if (w_rd) w_rdata <= w_mem[w_addr[11:0]];
  end

  always @(negedge clk) begin
    if (ifm_rd) ifm_log.push_back(ifm_addr);
    if (w_rd) w_log.push_back(w_addr);
    if (ifm_rd !== w_rd) pair_err++;
    if (mac_valid) begin
      mac_cnt++;
      if (mac_cnt == 1) first_in1 = mac_in1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name, input int hold, input bit poke);
    int lat;
    int keff;
    int idx;
    int aerr;
    int werr;
    logic [15:0] ea;
    keff = (v.k > 3'd5) ? 5 : int'(v.k);
    for (int i = 0; i < 4096; i++) begin
      ifm_mem[i] = v.ifm_val;
      w_mem[i]   = v.w_val;
    end
    ifm_log.delete();
    w_log.delete();
    mac_cnt  = 0;
    pair_err = 0;
    first_in1 = 16'hxxxx;
    @(negedge clk);
    cfg_ksize = v.k; cfg_ch = v.c; cfg_bias = v.bias; cfg_ifm_base = v.ifm_base;
    cfg_row_stride = v.rs; cfg_ch_stride = v.cs; cfg_w_base = v.wb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble cfg to prove it was latched at start.
    cfg_ksize = 3'd1; cfg_ch = 8'd9; cfg_bias = 16'hDEAD; cfg_ifm_base = 16'h0777;
    cfg_row_stride = 16'h0333; cfg_ch_stride = 16'h0555; cfg_w_base = 16'h0999;
    lat = -1;
    for (int cyc = 0; cyc <= 200; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk);
        #1;
      end
      if (res_valid) begin
        lat = cyc;
        break;
      end
    end
    check({name, " latency"}, lat, (v.n == 0) ? 0 : v.n + 3);
    check({name, " busy_at_result"}, busy, 1);
    check({name, " res_data"}, res_data, exp_post(v.exp_res));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      start = poke;
      @(posedge clk);
      #1;
      check({name, " hold_valid"}, res_valid, 1);
      check({name, " hold_data"}, res_data, exp_post(v.exp_res));
    end
    @(negedge clk);
    res_ready = 1'b1;
    start = poke;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    start = 1'b0;
    check({name, " idle_after_hs"}, {busy, res_valid}, 0);
    @(posedge clk);
    #1;
    check({name, " still_idle"}, busy, 0);
    aerr = 0;
    werr = 0;
    idx = 0;
    for (int ch = 0; ch < int'(v.c); ch++)
      for (int ky = 0; ky < keff; ky++)
        for (int kx = 0; kx < keff; kx++) begin
          ea = 16'(int'(v.ifm_base) + ch * int'(v.cs) + ky * int'(v.rs) + kx);
          if (idx >= ifm_log.size() || ifm_log[idx] !== ea) aerr++;
          if (idx >= w_log.size() || w_log[idx] !== 16'(int'(v.wb) + idx)) werr++;
          idx++;
        end
    check({name, " ifm_reads"}, ifm_log.size(), v.n);
    check({name, " w_reads"}, w_log.size(), v.n);
    check({name, " mac_pulses"}, mac_cnt, v.n);
    check({name, " ifm_addr_errs"}, aerr, 0);
    check({name, " w_addr_errs"}, werr, 0);
    check({name, " rd_pair_errs"}, pair_err, 0);
    if (v.n > 0) check({name, " bias_seed"}, first_in1, v.bias);
    $display("%s: K=%0d C=%0d res=0x%04h lat=%0d reads=%0d", name, v.k, v.c, res_data,
             lat, ifm_log.size());
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    start = 1'b0;
    res_ready = 1'b0;
    cfg_ksize = '0; cfg_ch = '0; cfg_bias = '0; cfg_ifm_base = '0;
    cfg_row_stride = '0; cfg_ch_stride = '0; cfg_w_base = '0;
    ifm_rdata = '0;
    w_rdata = '0;

    //        k     c     bias      base      rs        cs        wb        ifm       w         exp       n
    vecs[0] = '{3'd1, 8'd1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0200, 16'h0180, 16'h0400, 1};
    vecs[1] = '{3'd3, 8'd1, 16'h0000, 16'h0010, 16'h0020, 16'h0000, 16'h0000, 16'h0100, 16'h0100, 16'h0900, 9};
    vecs[2] = '{3'd2, 8'd2, 16'h7000, 16'h0040, 16'h0010, 16'h0100, 16'h0200, 16'h0400, 16'h0400, 16'h7FFF, 8};
    vecs[3] = '{3'd7, 8'd1, 16'h0000, 16'h0000, 16'h0008, 16'h0000, 16'h0300, 16'h0100, 16'h0020, 16'h0320, 25};
    vecs[4] = '{3'd3, 8'd0, 16'hFE80, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0100, 16'hFE80, 0};
    vecs[5] = '{3'd2, 8'd3, 16'hFF00, 16'hFFF0, 16'h0008, 16'h0004, 16'hFFFE, 16'h0080, 16'h0080, 16'h0200, 12};
    vecs[6] = '{3'd1, 8'd1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFF00, 16'h0100, 16'hFF00, 1};
    vecs[7] = '{3'd0, 8'd4, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0100, 16'h1234, 0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {busy, ifm_rd, w_rd, mac_valid, res_valid, ifm_addr, w_addr,
                            mac_in1, mac_in2, mac_in3, res_data}, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i), 0, 1'b0);
    end

    // Negative result held for 5 cycles with start pokes during the hold.
    run_vec(vecs[6], "hold_neg", 5, 1'b1);

    // Reset mid-window, then a clean restart.
    rv = '{3'd3, 8'd1, 16'h0100, 16'h0010, 16'h0020, 16'h0000, 16'h0000, 16'h0100, 16'h0100, 16'h0A00, 9};
    for (int i = 0; i < 4096; i++) begin
      ifm_mem[i] = 16'h0100;
      w_mem[i]   = 16'h0100;
    end
    @(negedge clk);
    cfg_ksize = 3'd3; cfg_ch = 8'd1; cfg_bias = 16'h0100; cfg_ifm_base = 16'h0010;
    cfg_row_stride = 16'h0020; cfg_ch_stride = 16'h0000; cfg_w_base = 16'h0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midwin_busy_rd", {busy, ifm_rd}, 2'b11);
    #1;
    rst = 1'b0;
    #1;
    check("abort_outputs", {busy, ifm_rd, w_rd, mac_valid, res_valid, ifm_addr, w_addr,
                            mac_in1, mac_in2, mac_in3, res_data}, 0);
    $display("abort: rst asserted at FETCH term 4, busy=%0d", busy);
    @(negedge clk);
    rst = 1'b1;
    run_vec(rv, "restart", 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
